// File: rtl/obstacle_renderer.sv
// -----------------------------------------------------------------------------
// obstacle_renderer
//
// Frame-tick driven sequencer that redraws the horizontal obstacle.
// On an accepted tick it walks every segment index, erasing each segment in
// the background colour, then pulses `move` so the obstacle block advances,
// waits one cycle for the segment array to settle, and walks the segments
// again plotting them in the obstacle colour.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   frame tick, only honoured in IDLE
//   endgame  in   blocks new sequences (a running one still completes)
//   h        out  segment index presented to the obstacle block
//   hin_x    in   x of segment h (combinational from the obstacle block)
//   hin_y    in   y of segment h (combinational from the obstacle block)
//   move     out  one-cycle pulse, obstacle advances one pixel
//   plot     out  registered VGA write enable
//   plot_x   out  registered VGA x
//   plot_y   out  registered VGA y
//   colour   out  registered VGA colour
//   busy     out  high whenever the sequencer is not idle
//   done     out  one-cycle pulse at the end of a sequence
// -----------------------------------------------------------------------------
module obstacle_renderer #(
  parameter int          SEGMENTS   = 10,
  parameter logic [2:0]  OBS_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       endgame,
  output logic [3:0] h,
  input  logic [7:0] hin_x,
  input  logic [6:0] hin_y,
  output logic       move,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  // Index of the final segment; the counter wraps to 0 when it reaches this.
  localparam logic [3:0] LAST_IDX = 4'(SEGMENTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_SETTLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t     state_reg,  state_next;
  logic [3:0] cnt_reg,    cnt_next;
  logic       plot_reg,   plot_next;
  logic [7:0] plot_x_reg, plot_x_next;
  logic [6:0] plot_y_reg, plot_y_next;
  logic [2:0] colour_reg, colour_next;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      plot_reg   <= 1'b0;
      plot_x_reg <= 8'd0;
      plot_y_reg <= 7'd0;
      colour_reg <= BG_COLOUR;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      plot_reg   <= plot_next;
      plot_x_reg <= plot_x_next;
      plot_y_reg <= plot_y_next;
      colour_reg <= colour_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // The segment coordinates arrive combinationally for the current index, so
  // they are captured straight into the plot registers: index t appears on
  // the VGA port in cycle t+1 with no gap between segments. Plot enable drops
  // in every non-walking state; the coordinate/colour registers simply hold
  // so the MOVE and DONE cycles still show the final write of each walk.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    plot_next   = 1'b0;
    plot_x_next = plot_x_reg;
    plot_y_next = plot_y_reg;
    colour_next = colour_reg;

    case (state_reg)
      S_IDLE: begin
        cnt_next = 4'd0;
        if (start && !endgame) begin
          state_next = S_ERASE;
        end
      end

      S_ERASE: begin
        plot_next   = 1'b1;
        plot_x_next = hin_x;
        plot_y_next = hin_y;
        colour_next = BG_COLOUR;
        if (cnt_reg == LAST_IDX) begin
          cnt_next   = 4'd0;
          state_next = S_MOVE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      S_MOVE: begin
        state_next = S_SETTLE;
      end

      // One spare cycle so the obstacle array has registered the move before
      // the draw walk reads the new coordinates.
      S_SETTLE: begin
        state_next = S_DRAW;
      end

      S_DRAW: begin
        plot_next   = 1'b1;
        plot_x_next = hin_x;
        plot_y_next = hin_y;
        colour_next = OBS_COLOUR;
        if (cnt_reg == LAST_IDX) begin
          cnt_next   = 4'd0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign h      = cnt_reg;
  assign move   = (state_reg == S_MOVE);
  assign done   = (state_reg == S_DONE);
  assign busy   = (state_reg != S_IDLE);
  assign plot   = plot_reg;
  assign plot_x = plot_x_reg;
  assign plot_y = plot_y_reg;
  assign colour = colour_reg;

endmodule

// File: tb/tb_obstacle_renderer.sv
// -----------------------------------------------------------------------------
// tb_obstacle_renderer
//
// Directed bench for obstacle_renderer. A small obstacle model supplies
// x = base + h + dir * (moves seen), y = constant, so erase and draw
// coordinates are known in advance. A second instance with SEGMENTS=1
// covers the single-segment case.
// -----------------------------------------------------------------------------
module tb_obstacle_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       endgame;
  logic [3:0] h;
  logic [7:0] hin_x;
  logic [6:0] hin_y;
  logic       move;
  logic       plot;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] colour;
  logic       busy;
  logic       done;

  // single-segment instance
  logic       start1;
  logic       endgame1;
  logic [3:0] h1;
  logic [7:0] hin_x1;
  logic [6:0] hin_y1;
  logic       move1;
  logic       plot1;
  logic [7:0] plot_x1;
  logic [6:0] plot_y1;
  logic [2:0] colour1;
  logic       busy1;
  logic       done1;

  int n_checks = 0;
  int n_fail   = 0;

  // obstacle model
  int obs_base = 0;
  int obs_dir  = 1;
  int obs_y    = 0;
  int mv0      = 0;
  int move_cnt = 0;
  int move1_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (move)  move_cnt  <= move_cnt + 1;
    if (move1) move1_cnt <= move1_cnt + 1;
  end

  assign hin_x  = 8'(obs_base + int'(h) + obs_dir * (move_cnt - mv0));
  assign hin_y  = 7'(obs_y);
  assign hin_x1 = 8'(50 + move1_cnt);
  assign hin_y1 = 7'd5;

  obstacle_renderer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .endgame (endgame),
    .h       (h),
    .hin_x   (hin_x),
    .hin_y   (hin_y),
    .move    (move),
    .plot    (plot),
    .plot_x  (plot_x),
    .plot_y  (plot_y),
    .colour  (colour),
    .busy    (busy),
    .done    (done)
  );

  obstacle_renderer #(.SEGMENTS(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .start   (start1),
    .endgame (endgame1),
    .h       (h1),
    .hin_x   (hin_x1),
    .hin_y   (hin_y1),
    .move    (move1),
    .plot    (plot1),
    .plot_x  (plot_x1),
    .plot_y  (plot_y1),
    .colour  (colour1),
    .busy    (busy1),
    .done    (done1)
  );

  // Expected {busy, move, done, plot} in cycle c of a 10-segment sequence
  // (cycle 1 = first ERASE cycle).
  function automatic logic [3:0] exp_ctl(input int c);
    logic b, m, d, p;
    b = (c >= 1) && (c <= 23);
    m = (c == 11);
    d = (c == 23);
    p = ((c >= 2) && (c <= 11)) || ((c >= 14) && (c <= 23));
    return {b, m, d, p};
  endfunction

  function automatic logic [3:0] exp_h(input int c);
    if (c >= 1 && c <= 10)  return 4'(c - 1);
    if (c >= 13 && c <= 22) return 4'(c - 13);
    return 4'd0;
  endfunction

  function automatic logic [7:0] exp_x(input int c, input int base, input int dir);
    if (c <= 11) return 8'(base + c - 2);
    return 8'(base + dir + c - 14);
  endfunction

  function automatic logic [2:0] exp_col(input int c);
    return (c <= 11) ? 3'b000 : 3'b100;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; endgame = 1'b0;
    start1 = 1'b0; endgame1 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({busy, move, done, plot} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000", {busy, move, done, plot});
    end
    n_checks++;
    if ({h, plot_x, plot_y, colour} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got h=%0d x=%0d y=%0d col=%b want all 0",
               h, plot_x, plot_y, colour);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  // One full start-pulse sequence with per-cycle checks. eg_at raises endgame
  // in that cycle, rs_at pulses start again while busy (0 = unused).
  task automatic test_sequence(input string name, input int base, input int dir,
                               input int y, input int eg_at, input int rs_at);
    int plots;
    int dones;
    plots = 0; dones = 0;
    obs_base = base; obs_dir = dir; obs_y = y; mv0 = move_cnt;
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      n_checks++;
      if ({busy, move, done, plot} !== exp_ctl(c)) begin
        n_fail++;
        $display("FAIL %s_ctl cycle %0d: busy/move/done/plot got %b want %b",
                 name, c, {busy, move, done, plot}, exp_ctl(c));
      end
      n_checks++;
      if (h !== exp_h(c)) begin
        n_fail++;
        $display("FAIL %s_h cycle %0d: got %0d want %0d", name, c, h, exp_h(c));
      end
      if (exp_ctl(c) & 4'b0001) begin
        n_checks++;
        if (plot_x !== exp_x(c, base, dir) || plot_y !== 7'(y) || colour !== exp_col(c)) begin
          n_fail++;
          $display("FAIL %s_pix cycle %0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   name, c, plot_x, plot_y, colour, exp_x(c, base, dir), y, exp_col(c));
        end
      end
      if (plot) plots++;
      if (done) dones++;
      if (c == eg_at) endgame = 1'b1;
      if (c == rs_at) start = 1'b1;
      if (rs_at != 0 && c == rs_at + 1) start = 1'b0;
    end
    endgame = 1'b0;
    n_checks++;
    if (plots !== 20 || dones !== 1) begin
      n_fail++;
      $display("FAIL %s_counts: plots=%0d done=%0d want 20 and 1", name, plots, dones);
    end
    $display("%s: sequence checked from base x=%0d", name, base);
  endtask

  task automatic test_basic();
    test_sequence("basic", 0, 1, 100, 0, 0);
  endtask

  task automatic test_held_start();
    int dones;
    int plots;
    int drained;
    dones = 0; plots = 0; drained = 0;
    obs_base = 10; obs_dir = 1; obs_y = 30; mv0 = move_cnt;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      n_checks++;
      if (busy !== ((c % 24) != 0)) begin
        n_fail++;
        $display("FAIL held_busy cycle %0d: got %b want %b", c, busy, (c % 24) != 0);
      end
      if (done) dones++;
      if (plot) plots++;
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 2 || plots !== 50) begin
      n_fail++;
      $display("FAIL held_counts: done=%0d plots=%0d want 2 and 50", dones, plots);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!busy) begin
        drained = 1;
        break;
      end
    end
    n_checks++;
    if (drained !== 1) begin
      n_fail++;
      $display("FAIL held_drain: busy still %b want 0 within 40 cycles", busy);
    end
    $display("held_start: %0d sequences completed in 60 cycles", dones);
  endtask

  task automatic test_endgame();
    int activity;
    activity = 0;
    endgame = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 3) start = 1'b0;
      if (busy || move || plot || done) activity++;
    end
    endgame = 1'b0;
    n_checks++;
    if (activity !== 0) begin
      n_fail++;
      $display("FAIL endgame_block: active cycles got %0d want 0", activity);
    end
    $display("endgame: start ignored while endgame=1");
    test_sequence("endgame_mid", 40, 1, 70, 5, 0);
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    obs_base = 20; obs_dir = 1; obs_y = 50; mv0 = move_cnt;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({busy, move, done, plot} !== 4'b0000 || h !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: busy/move/done/plot got %b h=%0d want 0000 h=0",
               {busy, move, done, plot}, h);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy || move || plot || done) stray++;
    end
    n_checks++;
    if (stray !== 0 || move_cnt !== mv0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: active cycles=%0d moves=%0d want 0 and 0",
               stray, move_cnt - mv0);
    end
    $display("reset_mid: sequence aborted at cycle 8");
    test_sequence("after_reset", 20, 1, 50, 0, 0);
  endtask

  task automatic test_busy_start();
    test_sequence("busy_start", 60, 1, 90, 0, 4);
  endtask

  task automatic test_right_edge();
    test_sequence("right_edge", 150, -1, 60, 0, 0);
  endtask

  task automatic test_single_segment();
    logic [3:0] want;
    logic [7:0] wx;
    logic [2:0] wc;
    start1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) start1 = 1'b0;
      want = {c <= 5, c == 2, c == 5, (c == 2) || (c == 5)};
      n_checks++;
      if ({busy1, move1, done1, plot1} !== want || h1 !== 4'd0) begin
        n_fail++;
        $display("FAIL single_ctl cycle %0d: busy/move/done/plot got %b h=%0d want %b h=0",
                 c, {busy1, move1, done1, plot1}, h1, want);
      end
      if (want[0]) begin
        wx = (c == 2) ? 8'd50 : 8'd51;
        wc = (c == 2) ? 3'b000 : 3'b100;
        n_checks++;
        if (plot_x1 !== wx || plot_y1 !== 7'd5 || colour1 !== wc) begin
          n_fail++;
          $display("FAIL single_pix cycle %0d: got (%0d,%0d,%b) want (%0d,5,%b)",
                   c, plot_x1, plot_y1, colour1, wx, wc);
        end
      end
    end
    $display("single_segment: 5-cycle sequence checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_start();
    test_endgame();
    test_reset_mid();
    test_busy_start();
    test_right_edge();
    test_single_segment();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_renderer.md
Name: obstacle_renderer

Overview:
- Reader/sequencer for the horizontal obstacle segment array.
- On each frame tick it walks the segment index `h`, reads back each segment's coordinates and erases every segment with the background colour.
- It then pulses `move` to advance the obstacle, re-reads all segments and plots them in the obstacle colour.
- Sits between the frame-rate tick generator, the obstacle block and the VGA adapter plot port.

Parameters:
- SEGMENTS, 10, number of obstacle segments to walk (index range 0..SEGMENTS-1, max 16).
- OBS_COLOUR, 3'b100, colour for drawing segments.
- BG_COLOUR, 3'b000, colour for erasing segments.

Ports:
- clock  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame tick; sampled only in IDLE.
- endgame  input  1  when 1, `start` is ignored; an in-flight sequence still completes.
- h  output  4  segment index presented to the obstacle block.
- hin_x  input  8  x of segment `h`, valid combinationally in the same cycle.
- hin_y  input  7  y of segment `h`, valid combinationally in the same cycle.
- move  output  1  one-cycle pulse: obstacle advances one pixel.
- plot  output  1  VGA write enable, registered.
- plot_x  output  8  VGA x, registered.
- plot_y  output  7  VGA y, registered.
- colour  output  3  VGA colour, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (synchronous, has priority over everything):
  - state=IDLE, cnt=0, plot=0, plot_x=0, plot_y=0, colour=BG_COLOUR.
  - move, done and busy are therefore 0.
- Reset mid-sequence: abort immediately. No further `move` or `plot` is issued and no `done`; partially erased pixels are left as they are.
- `h` = cnt (registered counter); `move` = (state==MOVE); `done` = (state==DONE); `busy` = (state!=IDLE).
- States:
  - IDLE: cnt=0. If start=1 and endgame=0, go to ERASE next cycle. Otherwise stay.
  - ERASE: each cycle, the next-edge registers load plot_x<=hin_x[7:0], plot_y<=hin_y, colour<=BG_COLOUR, plot<=1. cnt increments. When cnt==SEGMENTS-1, set cnt<=0 and go to MOVE.
  - MOVE: lasts 1 cycle and `move`=1. The plot registers still show the last erase write. At the edge, plot<=0. Go to SETTLE.
  - SETTLE: lasts 1 cycle. Lets the obstacle array update; no plot registered. Go to DRAW.
  - DRAW: same as ERASE but colour<=OBS_COLOUR. When cnt==SEGMENTS-1, set cnt<=0 and go to DONE.
  - DONE: lasts 1 cycle and `done`=1. The plot registers show the last draw write. At the edge, plot<=0. Go to IDLE.
- Latency and cycle counts:
  - Start accepted at edge E0; first ERASE cycle is cycle 1.
  - busy lasts 2*SEGMENTS+3 cycles (23 at default).
  - plot=1 for exactly SEGMENTS erase cycles (cycles 2..SEGMENTS+1) and SEGMENTS draw cycles (cycles SEGMENTS+4..2*SEGMENTS+3).
  - `move` is high only in cycle SEGMENTS+1 (11 at default).
- Plot pipeline: `h` is presented in cycle t; the matching plot appears in cycle t+1. There is no bubble between segments.
- Ordering: every erase of old positions precedes `move`, and every draw of new positions follows it. Writes are never interleaved.
- Boundaries:
  - `start` while busy is ignored; no queueing.
  - `start` held high re-triggers only after returning to IDLE, i.e. one sequence per IDLE visit.
  - `endgame` rising mid-sequence does not stop it.
  - cnt never exceeds SEGMENTS-1. `h` outside that range is never driven.
  - SEGMENTS=1 is legal: the ERASE and DRAW phases are each 1 cycle.

Test Plan:
- Reset then start pulse, obstacle at x=0..9, y=100:
  - erase plots (0,100)…(9,100) with colour 000 in cycles 2..11;
  - move high in cycle 11 only;
  - draw plots (1,100)…(10,100) with colour 100 in cycles 14..23;
  - done in cycle 23;
  - busy low in cycle 24.
- Start held high for 60 cycles: exactly two complete sequences, with busy dropping for one IDLE cycle between them; no overlapping plots.
- endgame=1 with a start pulse: no busy, move or plot ever. endgame rising at cycle 5 of a sequence: the sequence completes with all 20 plots and done.
- reset asserted at cycle 8 of a sequence: next cycle plot=0 and busy=0, with no move and no done. A later start gives a full 23-cycle sequence from cnt=0.
- Obstacle at right edge (x=150..159, moving left after this move): draw plots are x=149..158 in index order.
- start pulsed at cycle 4 while busy: ignored, and the total plot count stays 20.
